// File: rtl/letc_core_fetch2_buffer.sv
// Fetch-2 response buffer: pairs in-order imem responses with their request
// PCs and presents the oldest {pc, instr, fault} to decode. A flush empties the
// buffers and turns every in-flight request into a response that is dropped.
module letc_core_fetch2_buffer #(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stage_stall,
  input  logic        stage_flush,
  input  logic        f1_req_valid,
  input  logic [31:0] f1_req_pc,
  output logic        f1_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_instr,
  input  logic        imem_rsp_fault,
  output logic        f2_to_d_valid,
  output logic [31:0] f2_to_d_instr,
  output logic [31:0] f2_to_d_pc,
  output logic        f2_to_d_fault
);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = PW + 1;
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [PW-1:0] PTR_ZERO = PW'(0);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [CW+1:0] DEPTH_W  = (CW+2)'(DEPTH);

  // Pending-PC FIFO: requests issued to imem whose response has not arrived
  logic [31:0]   pend_pc_q [DEPTH];
  logic [31:0]   pend_pc_d [DEPTH];
  logic [PW-1:0] pend_wr_q, pend_wr_d, pend_rd_q, pend_rd_d;
  logic [CW-1:0] pend_cnt_q, pend_cnt_d;

  // Responses still owed by imem for requests that a flush killed
  logic [CW-1:0] drop_cnt_q, drop_cnt_d;

  // Instruction FIFO feeding decode
  logic [31:0]   buf_pc_q    [DEPTH];
  logic [31:0]   buf_pc_d    [DEPTH];
  logic [31:0]   buf_instr_q [DEPTH];
  logic [31:0]   buf_instr_d [DEPTH];
  logic          buf_fault_q [DEPTH];
  logic          buf_fault_d [DEPTH];
  logic [PW-1:0] buf_wr_q, buf_wr_d, buf_rd_q, buf_rd_d;
  logic [CW-1:0] buf_cnt_q, buf_cnt_d;

  logic [CW+1:0] occ_s;
  logic          drop_zero_s;
  logic          ready_s;
  logic          req_fire_s;
  logic          rsp_take_s;
  logic          rsp_drop_s;
  logic          pop_s;

  // Handshake decode; ready uses pre-edge counts so a same-cycle pop never frees a slot early
  always_comb begin
    occ_s       = {2'b00, pend_cnt_q} + {2'b00, drop_cnt_q} + {2'b00, buf_cnt_q};
    drop_zero_s = (drop_cnt_q == CNT_ZERO);
    ready_s     = !rst && !stage_flush && (occ_s < DEPTH_W);
    req_fire_s  = f1_req_valid && ready_s;
    rsp_take_s  = imem_rsp_valid && drop_zero_s;
    rsp_drop_s  = imem_rsp_valid && !drop_zero_s;
    pop_s       = !rst && !stage_flush && !stage_stall && (buf_cnt_q != CNT_ZERO);
  end

  // Next-state for both FIFOs and the drop counter
  always_comb begin
    pend_pc_d   = pend_pc_q;
    pend_wr_d   = pend_wr_q;
    pend_rd_d   = pend_rd_q;
    pend_cnt_d  = pend_cnt_q;
    drop_cnt_d  = drop_cnt_q;
    buf_pc_d    = buf_pc_q;
    buf_instr_d = buf_instr_q;
    buf_fault_d = buf_fault_q;
    buf_wr_d    = buf_wr_q;
    buf_rd_d    = buf_rd_q;
    buf_cnt_d   = buf_cnt_q;
    if (stage_flush) begin
      // Every outstanding request becomes a dropped response; one arriving now is already gone
      pend_wr_d  = PTR_ZERO;
      pend_rd_d  = PTR_ZERO;
      pend_cnt_d = CNT_ZERO;
      buf_wr_d   = PTR_ZERO;
      buf_rd_d   = PTR_ZERO;
      buf_cnt_d  = CNT_ZERO;
      drop_cnt_d = drop_cnt_q + pend_cnt_q - (imem_rsp_valid ? CNT_ONE : CNT_ZERO);
    end else begin
      if (req_fire_s) begin
        pend_pc_d[pend_wr_q] = f1_req_pc;
        pend_wr_d            = pend_wr_q + PTR_ONE;
      end else begin
        pend_wr_d = pend_wr_q;
      end
      if (rsp_drop_s) begin
        drop_cnt_d = drop_cnt_q - CNT_ONE;
      end else begin
        drop_cnt_d = drop_cnt_q;
      end
      if (rsp_take_s) begin
        pend_rd_d             = pend_rd_q + PTR_ONE;
        buf_pc_d[buf_wr_q]    = pend_pc_q[pend_rd_q];
        buf_instr_d[buf_wr_q] = imem_rsp_instr;
        buf_fault_d[buf_wr_q] = imem_rsp_fault;
        buf_wr_d              = buf_wr_q + PTR_ONE;
      end else begin
        pend_rd_d = pend_rd_q;
        buf_wr_d  = buf_wr_q;
      end
      if (pop_s) begin
        buf_rd_d = buf_rd_q + PTR_ONE;
      end else begin
        buf_rd_d = buf_rd_q;
      end
      pend_cnt_d = pend_cnt_q + (req_fire_s ? CNT_ONE : CNT_ZERO) - (rsp_take_s ? CNT_ONE : CNT_ZERO);
      buf_cnt_d  = buf_cnt_q + (rsp_take_s ? CNT_ONE : CNT_ZERO) - (pop_s ? CNT_ONE : CNT_ZERO);
    end
  end

  // State registers with synchronous reset; storage cleared so data outputs read 0 after reset
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_wr_q  <= PTR_ZERO;
      pend_rd_q  <= PTR_ZERO;
      pend_cnt_q <= CNT_ZERO;
      drop_cnt_q <= CNT_ZERO;
      buf_wr_q   <= PTR_ZERO;
      buf_rd_q   <= PTR_ZERO;
      buf_cnt_q  <= CNT_ZERO;
      for (int i = 0; i < int'(DEPTH); i++) begin
        pend_pc_q[i]   <= 32'h0000_0000;
        buf_pc_q[i]    <= 32'h0000_0000;
        buf_instr_q[i] <= 32'h0000_0000;
        buf_fault_q[i] <= 1'b0;
      end
    end else begin
      pend_pc_q   <= pend_pc_d;
      pend_wr_q   <= pend_wr_d;
      pend_rd_q   <= pend_rd_d;
      pend_cnt_q  <= pend_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
      buf_pc_q    <= buf_pc_d;
      buf_instr_q <= buf_instr_d;
      buf_fault_q <= buf_fault_d;
      buf_wr_q    <= buf_wr_d;
      buf_rd_q    <= buf_rd_d;
      buf_cnt_q   <= buf_cnt_d;
    end
  end

  assign f1_req_ready  = ready_s;
  assign f2_to_d_valid = pop_s;
  assign f2_to_d_pc    = buf_pc_q[buf_rd_q];
  assign f2_to_d_instr = buf_instr_q[buf_rd_q];
  assign f2_to_d_fault = buf_fault_q[buf_rd_q];

`ifndef SYNTHESIS
  // Every imem response must belong to a pending or a dropped request
  a_rsp_has_owner: assert property (@(posedge clk) disable iff (rst)
    !(imem_rsp_valid && (pend_cnt_q == CNT_ZERO) && (drop_cnt_q == CNT_ZERO)));
`endif

endmodule

// File: tb/tb_letc_core_fetch2_buffer.sv
// Scoreboard bench for letc_core_fetch2_buffer: a reference model of requests,
// drops and buffered instructions predicts ready/valid every cycle and the
// {pc, instr, fault} stream decode should see.
module tb_letc_core_fetch2_buffer;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stage_stall = 1'b0;
  logic        stage_flush = 1'b0;
  logic        f1_req_valid = 1'b0;
  logic [31:0] f1_req_pc = 32'h0;
  logic        f1_req_ready;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_instr = 32'h0;
  logic        imem_rsp_fault = 1'b0;
  logic        f2_to_d_valid;
  logic [31:0] f2_to_d_instr;
  logic [31:0] f2_to_d_pc;
  logic        f2_to_d_fault;

  int total = 0;
  int bad = 0;

  logic [31:0] req_q [$];
  logic [64:0] exp_q [$];
  int          drop_m = 0;

  letc_core_fetch2_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .stage_stall(stage_stall), .stage_flush(stage_flush),
    .f1_req_valid(f1_req_valid), .f1_req_pc(f1_req_pc), .f1_req_ready(f1_req_ready),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_instr(imem_rsp_instr), .imem_rsp_fault(imem_rsp_fault),
    .f2_to_d_valid(f2_to_d_valid), .f2_to_d_instr(f2_to_d_instr), .f2_to_d_pc(f2_to_d_pc),
    .f2_to_d_fault(f2_to_d_fault)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // One clock cycle: predict, compare, update the model, then advance and clear one-shot inputs
  task automatic cyc();
    logic        exp_ready;
    logic        exp_valid;
    logic [64:0] e;
    logic [31:0] rpc;
    #1;
    if (rst) begin
      exp_ready = 1'b0;
      exp_valid = 1'b0;
    end else begin
      exp_ready = !stage_flush && ((req_q.size() + exp_q.size() + drop_m) < DEPTH);
      exp_valid = (exp_q.size() != 0) && !stage_stall && !stage_flush;
    end
    total++;
    if (f1_req_ready !== exp_ready) begin
      bad++;
      $display("FAIL ready t=%0t got=%b want=%b", $time, f1_req_ready, exp_ready);
    end
    total++;
    if (f2_to_d_valid !== exp_valid) begin
      bad++;
      $display("FAIL valid t=%0t got=%b want=%b", $time, f2_to_d_valid, exp_valid);
    end
    if (rst) begin
      req_q.delete();
      exp_q.delete();
      drop_m = 0;
    end else begin
      if (exp_valid) begin
        e = exp_q.pop_front();
        total++;
        if ({f2_to_d_pc, f2_to_d_instr, f2_to_d_fault} !== e) begin
          bad++;
          $display("FAIL head t=%0t got pc=%h instr=%h fault=%b want pc=%h instr=%h fault=%b",
                   $time, f2_to_d_pc, f2_to_d_instr, f2_to_d_fault, e[64:33], e[32:1], e[0]);
        end
      end
      if (imem_rsp_valid) begin
        if (drop_m > 0) begin
          drop_m--;
        end else if (req_q.size() != 0) begin
          rpc = req_q.pop_front();
          if (!stage_flush) exp_q.push_back({rpc, imem_rsp_instr, imem_rsp_fault});
        end
      end
      if (f1_req_valid && exp_ready) req_q.push_back(f1_req_pc);
      if (stage_flush) begin
        drop_m += req_q.size();
        req_q.delete();
        exp_q.delete();
      end
    end
    @(posedge clk);
    @(negedge clk);
    f1_req_valid   = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_fault = 1'b0;
    stage_flush    = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) cyc();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d instructions never emitted, want 0", exp_q.size());
    end
  endtask

  task automatic test_reset();
    cyc();
    cyc();
    rst = 1'b0;
    #1;
    total++;
    if ({f2_to_d_pc, f2_to_d_instr, f2_to_d_fault} !== 65'd0) begin
      bad++;
      $display("FAIL reset_data: got pc=%h instr=%h fault=%b want zeros", f2_to_d_pc, f2_to_d_instr, f2_to_d_fault);
    end
    cyc();
  endtask

  task automatic test_basic();
    f1_req_valid = 1'b1; f1_req_pc = 32'h0000_1000; cyc();
    cyc();
    imem_rsp_valid = 1'b1; imem_rsp_instr = 32'h0000_0013; cyc();
    cyc();
    drain();
  endtask

  task automatic test_full();
    for (int i = 0; i < 4; i++) begin
      f1_req_valid = 1'b1; f1_req_pc = 32'h0000_4000 + 32'(i * 4); cyc();
    end
    f1_req_valid = 1'b1; f1_req_pc = 32'h0000_4010;
    #1;
    total++;
    if (f1_req_ready !== 1'b0) begin
      bad++;
      $display("FAIL full_ready: got=%b want=0", f1_req_ready);
    end
    cyc();
    imem_rsp_valid = 1'b1; imem_rsp_instr = 32'h1111_0001; cyc();
    f1_req_valid = 1'b1; f1_req_pc = 32'h0000_5000; cyc();
    #1;
    total++;
    if (f1_req_ready !== 1'b1) begin
      bad++;
      $display("FAIL ready_after_pop: got=%b want=1", f1_req_ready);
    end
    for (int i = 0; i < 3; i++) begin
      imem_rsp_valid = 1'b1; imem_rsp_instr = 32'h1111_0002 + 32'(i); cyc();
    end
    drain();
  endtask

  task automatic test_stall();
    stage_stall = 1'b1;
    f1_req_valid = 1'b1; f1_req_pc = 32'h0000_1000; cyc();
    f1_req_valid = 1'b1; f1_req_pc = 32'h0000_1004; cyc();
    imem_rsp_valid = 1'b1; imem_rsp_instr = 32'h0000_0013; cyc();
    imem_rsp_valid = 1'b1; imem_rsp_instr = 32'h0010_0093; cyc();
    for (int i = 0; i < 3; i++) begin
      #1;
      total++;
      if (f2_to_d_pc !== 32'h0000_1000 || f2_to_d_instr !== 32'h0000_0013) begin
        bad++;
        $display("FAIL stall_hold: got pc=%h instr=%h want pc=00001000 instr=00000013", f2_to_d_pc, f2_to_d_instr);
      end
      cyc();
    end
    stage_stall = 1'b0;
    cyc();
    cyc();
    drain();
  endtask

  task automatic test_flush();
    f1_req_valid = 1'b1; f1_req_pc = 32'h0000_2000; cyc();
    f1_req_valid = 1'b1; f1_req_pc = 32'h0000_2004; cyc();
    f1_req_valid = 1'b1; f1_req_pc = 32'h0000_2008;
    imem_rsp_valid = 1'b1; imem_rsp_instr = 32'h2222_0001; cyc();
    cyc();
    stage_flush = 1'b1; f1_req_valid = 1'b1; f1_req_pc = 32'h0000_2FFC;
    imem_rsp_valid = 1'b1; imem_rsp_instr = 32'h2222_0002; cyc();
    f1_req_valid = 1'b1; f1_req_pc = 32'h0000_3000;
    imem_rsp_valid = 1'b1; imem_rsp_instr = 32'h2222_0003; cyc();
    imem_rsp_valid = 1'b1; imem_rsp_instr = 32'h3333_0001; cyc();
    cyc();
    drain();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i <= 10; i++) begin
      if (i < 10) begin
        f1_req_valid = 1'b1; f1_req_pc = 32'h0000_6000 + 32'(i * 4);
      end
      if (i > 0) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_instr = 32'hA000_0000 + 32'(i - 1);
        imem_rsp_fault = ((i - 1) == 6);
      end
      cyc();
    end
    drain();
  endtask

  task automatic test_reset_mid();
    stage_stall = 1'b1;
    f1_req_valid = 1'b1; f1_req_pc = 32'h0000_7000; cyc();
    f1_req_valid = 1'b1; f1_req_pc = 32'h0000_7004; cyc();
    f1_req_valid = 1'b1; f1_req_pc = 32'h0000_7008;
    imem_rsp_valid = 1'b1; imem_rsp_instr = 32'h7777_0001; cyc();
    imem_rsp_valid = 1'b1; imem_rsp_instr = 32'h7777_0002; cyc();
    rst = 1'b1;
    stage_stall = 1'b0;
    cyc();
    rst = 1'b0;
    #1;
    total++;
    if (f1_req_ready !== 1'b1 || f2_to_d_valid !== 1'b0) begin
      bad++;
      $display("FAIL post_reset: got ready=%b valid=%b want ready=1 valid=0", f1_req_ready, f2_to_d_valid);
    end
    for (int i = 0; i < 5; i++) cyc();
    f1_req_valid = 1'b1; f1_req_pc = 32'h0000_8000; cyc();
    imem_rsp_valid = 1'b1; imem_rsp_instr = 32'h8888_0001; cyc();
    cyc();
    drain();
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    test_full();
    test_stall();
    test_flush();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
